// File: rtl/fftbin_fetch_ctrl_pkg.sv
// Shared types for the DOA bin-fetch path: default widths, fetch FSM states,
// and the complex sample layout downstream logic uses to unpack RAM words.
package fftbin_fetch_ctrl_pkg;

  localparam int DFLT_ADDR_W = 10;
  localparam int DFLT_DATA_W = 24;
  localparam int CPLX_W      = 12;

  typedef enum logic [2:0] {
    FS_IDLE    = 3'd0,
    FS_ISSUE   = 3'd1,
    FS_WAIT    = 3'd2,
    FS_PRESENT = 3'd3,
    FS_FINISH  = 3'd4
  } fetch_state_t;

  // RAM word layout: real part in the upper half, imaginary in the lower.
  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/fftbin_fetch_ctrl_if.sv
// Bin bundle stream from the fetch controller to the weight/DOA computation.
// Valid/ready: a bundle moves only when bin_valid and bin_ready are both high.
interface fftbin_fetch_ctrl_if
  import fftbin_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = DFLT_ADDR_W,
  parameter int DATA_W = DFLT_DATA_W
);

  logic              bin_valid;
  logic              bin_ready;
  logic [ADDR_W-1:0] bin_idx;
  logic [DATA_W-1:0] bin_q1;
  logic [DATA_W-1:0] bin_q2;
  logic [DATA_W-1:0] bin_q3;
  logic [DATA_W-1:0] bin_q4;
  logic              bin_last;

  modport master (
    output bin_valid, bin_idx, bin_q1, bin_q2, bin_q3, bin_q4, bin_last,
    input  bin_ready
  );

  modport slave (
    input  bin_valid, bin_idx, bin_q1, bin_q2, bin_q3, bin_q4, bin_last,
    output bin_ready
  );

endinterface

// File: rtl/fftbin_fetch_ctrl_window.sv
// Combinational window generator: maps (maxbin, beat pointer) to the candidate
// bin maxbin-1+ptr, whether it is a legal bin, and whether it ends the window.
module fftbin_fetch_ctrl_window #(
  parameter int NBINS  = 512,
  parameter int ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] maxbin,
  input  logic [1:0]        ptr,
  output logic [ADDR_W-1:0] cand_addr,
  output logic              in_range,
  output logic              is_last
);

  // One guard bit beyond the signed address so maxbin+1 can never wrap.
  logic signed [ADDR_W+1:0] cand;

  assign cand = $signed({2'b00, maxbin})
              + $signed({{ADDR_W{1'b0}}, ptr})
              - $signed((ADDR_W+2)'(1));

  assign cand_addr = cand[ADDR_W-1:0];
  assign in_range  = !cand[ADDR_W+1] && (int'(cand) < NBINS);

  // Legal bins form a contiguous run, so the window ends at the third
  // candidate or wherever the next one would fall off the top.
  assign is_last = in_range && ((ptr == 2'd2) || (int'(cand) + 1 >= NBINS));

endmodule

// File: rtl/fftbin_fetch_ctrl.sv
// Fetches the 4-mic bins around freqdetect's dominant bin and streams them out;
// passes freqdetect's read address through to the RAMs whenever idle.
module fftbin_fetch_ctrl
  import fftbin_fetch_ctrl_pkg::*;
#(
  parameter int NBINS  = 512,
  parameter int ADDR_W = DFLT_ADDR_W,
  parameter int DATA_W = DFLT_DATA_W,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                detectdone,
  input  logic [ADDR_W-1:0]   maxbin,
  input  logic [ADDR_W-1:0]   fd_rdaddr,
  output logic [ADDR_W-1:0]   ram_rdaddr,
  input  logic [DATA_W-1:0]   ram1q,
  input  logic [DATA_W-1:0]   ram2q,
  input  logic [DATA_W-1:0]   ram3q,
  input  logic [DATA_W-1:0]   ram4q,
  fftbin_fetch_ctrl_if.master bin,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [2:0] IDLE    = FS_IDLE;
  localparam logic [2:0] ISSUE   = FS_ISSUE;
  localparam logic [2:0] WAIT    = FS_WAIT;
  localparam logic [2:0] PRESENT = FS_PRESENT;
  localparam logic [2:0] FINISH  = FS_FINISH;

  logic [2:0]        state;
  logic [ADDR_W-1:0] maxbin_q;
  logic [1:0]        ptr;
  logic [LAT_W-1:0]  lat_cnt;
  logic [ADDR_W-1:0] addr_q;

  logic [ADDR_W-1:0] cand_addr;
  logic              cand_ok;
  logic              cand_last;
  logic              maxbin_oob;

  fftbin_fetch_ctrl_window #(
    .NBINS  (NBINS),
    .ADDR_W (ADDR_W)
  ) u_window (
    .maxbin    (maxbin_q),
    .ptr       (ptr),
    .cand_addr (cand_addr),
    .in_range  (cand_ok),
    .is_last   (cand_last)
  );

  assign maxbin_oob = 32'(maxbin) >= NBINS;
  assign busy       = (state != IDLE);
  assign done       = (state == FINISH);

  // The RAMs belong to freqdetect except while a fetch is actually in flight.
  always_comb begin
    ram_rdaddr = fd_rdaddr;
    case (state)
      ISSUE:         ram_rdaddr = cand_addr;
      WAIT, PRESENT: ram_rdaddr = addr_q;
      default:       ram_rdaddr = fd_rdaddr;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      maxbin_q      <= '0;
      ptr           <= '0;
      lat_cnt       <= '0;
      addr_q        <= '0;
      err           <= 1'b0;
      bin.bin_valid <= 1'b0;
      bin.bin_last  <= 1'b0;
      bin.bin_idx   <= '0;
      bin.bin_q1    <= '0;
      bin.bin_q2    <= '0;
      bin.bin_q3    <= '0;
      bin.bin_q4    <= '0;
    end else begin
      err <= detectdone && ((state != IDLE) || maxbin_oob);

      case (state)
        IDLE: begin
          if (detectdone) begin
            if (maxbin_oob) begin
              state <= FINISH;
            end else begin
              maxbin_q <= maxbin;
              // maxbin-1 is only illegal at bin 0; start one candidate later.
              ptr      <= (maxbin == '0) ? 2'd1 : 2'd0;
              state    <= ISSUE;
            end
          end
        end

        ISSUE: begin
          addr_q  <= cand_addr;
          lat_cnt <= LAT_W'(RD_LAT - 1);
          state   <= cand_ok ? WAIT : FINISH;
        end

        WAIT: begin
          if (lat_cnt == '0) begin
            bin.bin_q1    <= ram1q;
            bin.bin_q2    <= ram2q;
            bin.bin_q3    <= ram3q;
            bin.bin_q4    <= ram4q;
            bin.bin_idx   <= addr_q;
            bin.bin_last  <= cand_last;
            bin.bin_valid <= 1'b1;
            state         <= PRESENT;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end

        PRESENT: begin
          if (bin.bin_ready) begin
            bin.bin_valid <= 1'b0;
            if (bin.bin_last) begin
              state <= FINISH;
            end else begin
              ptr   <= ptr + 2'd1;
              state <= ISSUE;
            end
          end
        end

        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fftbin_fetch_ctrl.sv
// Scoreboarded bench: a window model queues expected bundles per detectdone,
// and a negedge monitor checks every presented bundle, pulse and address.
`timescale 1ns/1ps
module tb_fftbin_fetch_ctrl;
  import fftbin_fetch_ctrl_pkg::*;

  localparam int NBINS  = 512;
  localparam int ADDR_W = DFLT_ADDR_W;
  localparam int DATA_W = DFLT_DATA_W;
  localparam int RD_LAT = 2;

  typedef struct {
    logic [ADDR_W-1:0] idx;
    logic              last;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              detectdone;
  logic [ADDR_W-1:0] maxbin;
  logic [ADDR_W-1:0] fd_rdaddr;
  logic [ADDR_W-1:0] ram_rdaddr;
  logic [DATA_W-1:0] ram1q, ram2q, ram3q, ram4q;
  logic              busy, done, err;

  fftbin_fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bi ();

  fftbin_fetch_ctrl #(
    .NBINS(NBINS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset(reset), .detectdone(detectdone), .maxbin(maxbin),
    .fd_rdaddr(fd_rdaddr), .ram_rdaddr(ram_rdaddr),
    .ram1q(ram1q), .ram2q(ram2q), .ram3q(ram3q), .ram4q(ram4q),
    .bin(bi), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t exp_q[$];
  time   t0 = 0;
  int    first_valid_off, done_off, err_off;
  int    done_cnt, err_cnt, beats_seen;
  int    ready_mode = 0;
  int    stall_left = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] ramword(input int mic, input logic [ADDR_W-1:0] a);
    return {mic[3:0], a, a ^ 10'h2a5};
  endfunction

  // RAM model: address registered through RD_LAT stages before data appears.
  logic [ADDR_W-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    pipe[0] <= ram_rdaddr;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram1q = ramword(1, pipe[RD_LAT-1]);
  assign ram2q = ramword(2, pipe[RD_LAT-1]);
  assign ram3q = ramword(3, pipe[RD_LAT-1]);
  assign ram4q = ramword(4, pipe[RD_LAT-1]);

  always @(posedge clk) begin
    #1;
    fd_rdaddr = ADDR_W'($urandom_range(0, NBINS - 1));
  end

  // Ready modes: 0 always high, 1 stall on the second bundle, 2 random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: begin
        if (bi.bin_valid && beats_seen == 1 && stall_left > 0) begin
          bi.bin_ready = 1'b0;
          stall_left--;
        end else begin
          bi.bin_ready = 1'b1;
        end
      end
      2:       bi.bin_ready = 1'($urandom_range(0, 1));
      default: bi.bin_ready = 1'b1;
    endcase
  end

  // Reference window: neighbours of m kept only where they are legal bins.
  function automatic int model_push(input int m);
    beat_t b;
    int    n = 0;
    if (m >= NBINS) return 0;
    for (int c = m - 1; c <= m + 1; c++) begin
      if (c >= 0 && c < NBINS) begin
        b.idx  = ADDR_W'(c);
        b.last = 1'b0;
        exp_q.push_back(b);
        n++;
      end
    end
    exp_q[exp_q.size()-1].last = 1'b1;
    return n;
  endfunction

  always @(negedge clk) begin
    int rel;
    if (reset) begin
      rel = int'(($time - t0 - 5) / 10) + 1;
      if (!busy) check("idle_passthrough", ram_rdaddr, fd_rdaddr);
      else       check("addr_in_range", ram_rdaddr < NBINS, 1);
      if (bi.bin_valid) begin
        if (first_valid_off < 0) first_valid_off = rel;
        if (exp_q.size() == 0) begin
          check("unexpected_bundle", bi.bin_idx, -1);
        end else begin
          check("bin_idx", bi.bin_idx, exp_q[0].idx);
          check("bin_last", bi.bin_last, exp_q[0].last);
          check("bin_q1", bi.bin_q1, ramword(1, exp_q[0].idx));
          check("bin_q2", bi.bin_q2, ramword(2, exp_q[0].idx));
          check("bin_q3", bi.bin_q3, ramword(3, exp_q[0].idx));
          check("bin_q4", bi.bin_q4, ramword(4, exp_q[0].idx));
          check("addr_held", ram_rdaddr, exp_q[0].idx);
          if (bi.bin_ready) begin
            void'(exp_q.pop_front());
            beats_seen++;
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_off = rel;
        if (beats_seen == 0) check("finish_passthrough", ram_rdaddr, fd_rdaddr);
      end
      if (err) begin
        err_cnt++;
        err_off = rel;
      end
    end
  end

  task automatic run_window(input int m, input int rmode, input int stall_len, input bit extra_dd);
    int nb;
    first_valid_off = -1; done_off = -1; err_off = -1;
    done_cnt = 0; err_cnt = 0; beats_seen = 0;
    nb = model_push(m);
    ready_mode = rmode;
    stall_left = stall_len;
    @(posedge clk); #1;
    detectdone = 1'b1;
    maxbin     = ADDR_W'(m);
    @(posedge clk);
    t0 = $time;
    #1;
    detectdone = 1'b0;
    maxbin     = ADDR_W'($urandom);
    if (extra_dd) begin
      repeat (4) @(posedge clk);
      #1;
      detectdone = 1'b1;
      maxbin     = ADDR_W'($urandom_range(0, NBINS - 1));
      @(posedge clk); #1;
      detectdone = 1'b0;
    end
    for (int i = 0; i < 300 && done_cnt == 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("done_count", done_cnt, 1);
    check("bundles_left", exp_q.size(), 0);
    check("bundle_count", beats_seen, nb);
    if (m >= NBINS) begin
      check("oob_err_count", err_cnt, 1);
      check("oob_err_time", err_off, 1);
      check("oob_done_time", done_off, 1);
      check("oob_no_valid", first_valid_off, -1);
    end else begin
      check("err_count", err_cnt, extra_dd ? 1 : 0);
      if (extra_dd) check("busy_err_time", err_off, 6);
      if (rmode != 2) begin
        check("first_valid_time", first_valid_off, 2 + RD_LAT);
        check("done_time", done_off, nb * (RD_LAT + 2) + 1 + stall_len);
      end
    end
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, bi.bin_valid, 0);
    check({tag, "_last"}, bi.bin_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_idx"}, bi.bin_idx, 0);
    check({tag, "_q1"}, bi.bin_q1, 0);
    check({tag, "_q4"}, bi.bin_q4, 0);
    check({tag, "_addr"}, ram_rdaddr, fd_rdaddr);
  endtask

  initial begin
    int r, m;
    reset        = 1'b0;
    detectdone   = 1'b0;
    maxbin       = '0;
    fd_rdaddr    = '0;
    bi.bin_ready = 1'b1;
    #2;
    check_reset_outputs("por");
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("por_hold");
    reset = 1'b1;
    repeat (2) @(posedge clk);

    run_window(100, 0, 0, 1'b0);
    run_window(0, 0, 0, 1'b0);
    run_window(NBINS - 1, 0, 0, 1'b0);
    run_window(600, 0, 0, 1'b0);
    run_window(50, 1, 5, 1'b0);
    run_window(100, 0, 0, 1'b1);

    // Reset landing in WAIT abandons the window without a done pulse.
    done_cnt = 0;
    void'(model_push(200));
    @(posedge clk); #1;
    detectdone = 1'b1;
    maxbin     = 10'd200;
    @(posedge clk); #1;
    detectdone = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    check("mid_reset_no_done", done_cnt, 0);
    check("mid_reset_idle", busy, 0);

    for (int k = 0; k < 24; k++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       m = $urandom_range(0, NBINS - 1);
      else if (r == 7) m = 0;
      else if (r == 8) m = NBINS - 1;
      else             m = $urandom_range(NBINS, 1023);
      run_window(m, ($urandom_range(0, 1) == 1) ? 2 : 0, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
